interp_seq_h2: RTL

//  Sequencer for the second-antenna interpolation path of channel estimation.

---
 rtl/interp_seq_h2_pkg.sv | 43 ++++
 rtl/interp_seq_h2_if.sv | 26 ++
 rtl/interp_seq_h2_re_counter.sv | 45 ++++
 rtl/interp_seq_h2.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/interp_seq_h2_pkg.sv
// Shared definitions for the second-antenna interpolation sequencer: default geometry,
// h_eqlz_2 mux select encodings (also consumed by the mux), FSM states and select mapping.
package interp_seq_h2_pkg;

   localparam int N_SC_DEF    = 12;
   localparam int N_SYM_DEF   = 14;
   localparam int PILOT_A_DEF = 5;
   localparam int PILOT_B_DEF = 6;
   localparam int TMO_CYC_DEF = 64;

   localparam logic [1:0] SEL_DIV2 = 2'b00;
   localparam logic [1:0] SEL_EST3 = 2'b01;
   localparam logic [1:0] SEL_DIV1 = 2'b10;
   localparam logic [1:0] SEL_EST4 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_EST = 3'd1,
      ST_SEL      = 3'd2,
      ST_DIV_REQ  = 3'd3,
      ST_DIV_WAIT = 3'd4,
      ST_OUT      = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   // Symbols before the first pilot use div_res_1, symbols after the second use div_res_2.
   function automatic logic [1:0] sel_for_sym(input logic [3:0] sym,
                                              input logic [3:0] pilot_a,
                                              input logic [3:0] pilot_b);
      logic [1:0] s;
      if (sym == pilot_a) begin
         s = SEL_EST3;
      end else if (sym == pilot_b) begin
         s = SEL_EST4;
      end else if (sym < pilot_a) begin
         s = SEL_DIV1;
      end else begin
         s = SEL_DIV2;
      end
      return s;
   endfunction

endpackage

// File: rtl/interp_seq_h2_if.sv
// Handshake/control bundle between the interpolation sequencer and its environment.
interface interp_seq_h2_if;
   logic       start;
   logic       est_valid;
   logic       div_done;
   logic       out_ready;
   logic       div_req;
   logic [1:0] sel;
   logic       out_valid;
   logic [3:0] sym_idx;
   logic [3:0] sc_idx;
   logic       last;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start, est_valid, div_done, out_ready,
      input  div_req, sel, out_valid, sym_idx, sc_idx, last, busy, done, err
   );

   modport slave (
      input  start, est_valid, div_done, out_ready,
      output div_req, sel, out_valid, sym_idx, sc_idx, last, busy, done, err
   );
endinterface

// File: rtl/interp_seq_h2_re_counter.sv
// Subcarrier/symbol RE counter: sc wraps at N_SC-1 and carries into sym; last_re marks
// the final RE of the subframe.
module h2_re_counter #(
   parameter int N_SC  = 12,
   parameter int N_SYM = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] sym,
   output logic [3:0] sc,
   output logic       last_re
);

   logic sc_wrap_s;
   logic sym_wrap_s;

   assign sc_wrap_s  = (sc == 4'(N_SC - 1));
   assign sym_wrap_s = (sym == 4'(N_SYM - 1));
   assign last_re    = sc_wrap_s && sym_wrap_s;

   // RE position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym <= 4'd0;
         sc  <= 4'd0;
      end else if (clr) begin
         sym <= 4'd0;
         sc  <= 4'd0;
      end else if (en) begin
         if (sc_wrap_s) begin
            sc  <= 4'd0;
            sym <= sym_wrap_s ? 4'd0 : sym + 4'd1;
         end else begin
            sc  <= sc + 4'd1;
            sym <= sym;
         end
      end else begin
         sym <= sym;
         sc  <= sc;
      end
   end

endmodule

// File: rtl/interp_seq_h2.sv
// Second-antenna interpolation sequencer: walks every RE of a subframe, requests divider
// results for non-pilot symbols and hands h_eqlz_2 to the equaliser. Optional: H2_TIMEOUT_EN.
module interp_seq_h2
   import interp_seq_h2_pkg::*;
#(
   parameter int N_SC    = N_SC_DEF,
   parameter int N_SYM   = N_SYM_DEF,
   parameter int PILOT_A = PILOT_A_DEF,
   parameter int PILOT_B = PILOT_B_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input logic             clk,
   input logic             rst_n,
   interp_seq_h2_if.slave  bus
);

   state_t     state_r;
   logic [1:0] sel_r;
   logic       div_req_r;
   logic       out_valid_r;
   logic       last_r;
   logic       busy_r;
   logic       done_r;

   logic       cnt_clr_s;
   logic       cnt_en_s;
   logic [3:0] sym_s;
   logic [3:0] sc_s;
   logic       last_re_s;
   logic       pilot_s;
   logic       tmo_hit_s;

   assign cnt_clr_s = (state_r == ST_IDLE) && bus.start;
   assign cnt_en_s  = (state_r == ST_OUT) && bus.out_ready;
   assign pilot_s   = (sym_s == 4'(PILOT_A)) || (sym_s == 4'(PILOT_B));

   h2_re_counter #(
      .N_SC  (N_SC),
      .N_SYM (N_SYM)
   ) u_re_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr_s),
      .en      (cnt_en_s),
      .sym     (sym_s),
      .sc      (sc_s),
      .last_re (last_re_s)
   );

`ifdef H2_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_cnt_r;
   logic          err_r;

   assign tmo_hit_s = (tmo_cnt_r == TW'(TMO_CYC - 1));

   // Divider wait counter, restarted whenever the FSM is outside DIV_WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= '0;
      end else if ((state_r == ST_DIV_WAIT) && !bus.div_done) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= '0;
      end
   end

   // Sticky timeout flag, cleared only by an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (cnt_clr_s) begin
         err_r <= 1'b0;
      end else if ((state_r == ST_DIV_WAIT) && !bus.div_done && tmo_hit_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.err = err_r;
`else
   assign tmo_hit_s = 1'b0;
   assign bus.err   = 1'b0;
`endif

   // Sequencer FSM; every output is registered on the transition into the state that owns it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         sel_r       <= SEL_DIV2;
         div_req_r   <= 1'b0;
         out_valid_r <= 1'b0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         div_req_r <= 1'b0;
         done_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_r <= ST_WAIT_EST;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT_EST: begin
               if (bus.est_valid) begin
                  state_r <= ST_SEL;
               end else begin
                  state_r <= ST_WAIT_EST;
               end
            end
            ST_SEL: begin
               sel_r <= sel_for_sym(sym_s, 4'(PILOT_A), 4'(PILOT_B));
               if (pilot_s) begin
                  state_r     <= ST_OUT;
                  out_valid_r <= 1'b1;
                  last_r      <= last_re_s;
               end else begin
                  state_r   <= ST_DIV_REQ;
                  div_req_r <= 1'b1;
               end
            end
            // div_done is deliberately not looked at here
            ST_DIV_REQ: begin
               state_r <= ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
               if (bus.div_done) begin
                  state_r     <= ST_OUT;
                  out_valid_r <= 1'b1;
                  last_r      <= last_re_s;
               end else if (tmo_hit_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_DIV_WAIT;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  last_r      <= 1'b0;
                  if (last_re_s) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_SEL;
                  end
               end else begin
                  state_r <= ST_OUT;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               last_r      <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.div_req   = div_req_r;
   assign bus.sel       = sel_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sym_idx   = sym_s;
   assign bus.sc_idx    = sc_s;
   assign bus.last      = last_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule
